// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts a
// command byte plus odd parity on device clock falling edges, then checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  inout  wire        keyb_clk,
  inout  wire        keyb_data,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);
  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SHIFT, ACK, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_q, edge_d;
  logic [8:0]       shift_q, shift_d;
  logic             data_low_q, data_low_d;
  logic             ack_ok_q, ack_ok_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [2:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             clk_s, data_s, clk_fall, expired;

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign expired  = (cnt_q == TO_LAST);

  // Open-drain drivers: only ever pull low or float.
  assign keyb_clk  = (state_q == INHIBIT) ? 1'b0 : 1'bz;
  assign keyb_data = data_low_q ? 1'b0 : 1'bz;

  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tx_done   = done_q;
  assign tx_ack_ok = ack_ok_q;
  assign tx_error  = error_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    shift_d    = shift_q;
    data_low_d = data_low_q;
    ack_ok_d   = ack_ok_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d  = INHIBIT;
          cnt_d    = '0;
          shift_d  = {~^tx_data, tx_data};
          ack_ok_d = 1'b0;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d    = REQUEST;
          cnt_d      = '0;
          data_low_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQUEST, SHIFT, ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Expiry is checked first so it beats a coincident device edge.
        if (expired) begin
          state_d    = IDLE;
          cnt_d      = '0;
          data_low_d = 1'b0;
          ack_ok_d   = 1'b0;
          error_d    = 1'b1;
        end else if (state_q == REQUEST) begin
          edge_d  = '0;
          state_d = SHIFT;
        end else if (clk_fall) begin
          if (state_q == ACK) begin
            ack_ok_d = ~data_s;
            cnt_d    = '0;
            state_d  = RELEASE;
          end else begin
            edge_d = edge_q + 4'd1;
            if (edge_q == 4'd9) begin
              data_low_d = 1'b0;
              state_d    = ACK;
            end else begin
              data_low_d = ~shift_q[0];
              shift_d    = {1'b0, shift_q[8:1]};
            end
          end
        end
      end
      RELEASE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      edge_q      <= '0;
      shift_q     <= '0;
      data_low_q  <= 1'b0;
      ack_ok_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      shift_q     <= shift_d;
      data_low_q  <= data_low_d;
      ack_ok_q    <= ack_ok_d;
      done_q      <= done_d;
      error_q     <= error_d;
      clk_sync_q  <= {clk_sync_q[1:0], keyb_clk};
      data_sync_q <= {data_sync_q[0], keyb_data};
    end
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, 5000, clk cycles keyb_clk is held low before the request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, 750000, clk cycles allowed from request release to ack sample (15 ms at 50 MHz).
REQ-003 clk  input  1  system clock, 50 MHz, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  8  command byte to send to the keyboard.
REQ-006 tx_valid  input  1  request; byte accepted on the cycle tx_valid and tx_ready are both high.
REQ-007 tx_ready  output  1  high only in IDLE.
REQ-008 keyb_clk  inout  1  PS/2 clock, open-drain: drive 0 or Z only.
REQ-009 keyb_data  inout  1  PS/2 data, open-drain: drive 0 or Z only.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 tx_done  output  1  one-cycle pulse at transfer end; tx_ack_ok is valid in the same cycle.
REQ-012 tx_ack_ok  output  1  ack bit sampled 0; held until the next accept.
REQ-013 tx_error  output  1  one-cycle pulse on timeout.

Function
REQ-014 keyb_clk and keyb_data are each synchronised by a 2-FF chain.
REQ-015 A device clock falling edge is the synchronised value changing 1->0.
REQ-016 On accept, the block latches tx_data and computes odd parity: parity bit = ~^tx_data.
REQ-017 States: IDLE, INHIBIT, REQUEST, SHIFT, ACK, RELEASE.
REQ-018 IDLE: both lines Z; on accept, go to INHIBIT and clear tx_ack_ok.
REQ-019 INHIBIT: drive keyb_clk 0 for exactly INHIBIT_CYCLES cycles, then go to REQUEST.
REQ-020 REQUEST, one cycle: drive keyb_data 0 (start bit), release keyb_clk, clear the edge counter and the timeout counter, go to SHIFT.
REQ-021 SHIFT: data changes only on device falling edges, counted 1..10:
- edges 1-8: drive bit[n-1], LSB first (0 -> drive 0, 1 -> Z);
- edge 9: drive the parity bit;
- edge 10: release keyb_data (stop bit = 1) and go to ACK.
REQ-022 ACK: on the next falling edge, sample synchronised keyb_data; tx_ack_ok = (sample == 0); go to RELEASE.
REQ-023 RELEASE: wait until both synchronised lines are 1, then pulse tx_done and return to IDLE.
REQ-024 Timeout counter runs from REQUEST through ACK.
REQ-025 On reaching TIMEOUT_CYCLES: release both lines, pulse tx_error, no tx_done, tx_ack_ok = 0, return to IDLE.
REQ-026 The block does not drive keyb_clk low outside INHIBIT.
REQ-027 tx_valid is ignored outside IDLE; the latched byte is unaffected by tx_data changes mid-transfer.
REQ-028 A falling edge in the same cycle as timeout expiry: timeout wins.
REQ-029 Counter widths are sized from the parameters; no wrap before terminal count.

Reset
REQ-030 While reset = 0: state IDLE, both lines Z (asynchronously, including mid-transfer).
REQ-031 Reset values: tx_ready 1, busy 0, tx_done 0, tx_ack_ok 0, tx_error 0, counters 0, synchronisers 1.
REQ-032 After release of reset, the first accept is possible on the first clk edge with tx_valid high.

Verification
REQ-033 Both lines on pull-ups; the device model clocks at about 12 kHz after seeing data low with clk released, then acks by pulling data low for the 11th clock.
REQ-034 Send 0xED -> keyb_clk low for 5000 cycles, then data bits 1,0,1,1,0,1,1,1, parity 1, stop released; model ack 0 -> tx_done pulse, tx_ack_ok = 1.
REQ-035 Send 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0; model samples byte 0xF4 with good parity.
REQ-036 Send 0x00 (parity 1) and 0xFF (parity 1) back to back -> second accept only after the first tx_done; tx_ready low throughout.
REQ-037 Model never clocks -> tx_error pulse exactly TIMEOUT_CYCLES after REQUEST, lines Z, tx_ready 1.
REQ-038 Model returns ack = 1 -> tx_done pulse with tx_ack_ok = 0.
REQ-039 Reset asserted at edge 5 -> lines Z in the same cycle, outputs at reset values; a new 0xED transfer then completes normally.
